// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared data-bus encodings, state type and address constants
package dbus_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'hFF00_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } dbus_state_e;

    // Size 11 is never legal; word and halfword need natural alignment.
    function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_WORD: access_illegal = (addr_lo != 2'b00);
            SIZE_HALF: access_illegal = addr_lo[0];
            SIZE_BYTE: access_illegal = 1'b0;
            default:   access_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dbus_load_align.sv
// rtl/dbus_load_align.sv - extends right-justified load data by access size and signedness
module dbus_load_align
    import dbus_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] ddt,
    input  logic [1:0]           size,
    input  logic                 sign_ext,
    output logic [BIT_WIDTH-1:0] rdata
);

    always_comb begin
        rdata = '0;
        case (size)
            SIZE_WORD: rdata = ddt;
            SIZE_HALF: rdata = {{(BIT_WIDTH-16){sign_ext & ddt[15]}}, ddt[15:0]};
            SIZE_BYTE: rdata = {{(BIT_WIDTH-8){sign_ext & ddt[7]}}, ddt[7:0]};
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_bus_master.sv
// rtl/dmem_bus_master.sv - MEM-stage initiator for the DAD/DDT/MREQ/ACKD_n data-memory bus
module dmem_bus_master
    import dbus_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 stall,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 err_misaligned,
    output logic                 err_timeout,
    output logic [BIT_WIDTH-1:0] DAD,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dbus_state_e          state;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 ddt_oe;
    logic                 sign_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [BIT_WIDTH-1:0] store_lane;
    logic [BIT_WIDTH-1:0] load_data;

    assign req_ready = (state == ST_IDLE);
    assign stall     = (state == ST_BUS) | ((state == ST_IDLE) & req_valid);
    assign DDT       = ddt_oe ? wdata_q : 'z;

    always_comb begin
        store_lane = req_wdata;
        case (req_size)
            SIZE_HALF: store_lane = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
            SIZE_BYTE: store_lane = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
            default:   store_lane = req_wdata;
        endcase
    end

    dbus_load_align #(.BIT_WIDTH(BIT_WIDTH)) u_load_align (
        .ddt      (DDT),
        .size     (SIZE),
        .sign_ext (sign_q),
        .rdata    (load_data)
    );

    // Response fields default to zero every edge so they pulse for exactly the RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            ddt_oe         <= 1'b0;
            sign_q         <= 1'b0;
            wdata_q        <= '0;
            DAD            <= '0;
            MREQ           <= 1'b0;
            WRITE          <= 1'b0;
            SIZE           <= SIZE_WORD;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            err_misaligned <= 1'b0;
            err_timeout    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (access_illegal(req_size, req_addr[1:0])) begin
                            state          <= ST_RESP;
                            resp_valid     <= 1'b1;
                            err_misaligned <= 1'b1;
                        end else begin
                            state    <= ST_BUS;
                            MREQ     <= 1'b1;
                            WRITE    <= req_write;
                            SIZE     <= req_size;
                            DAD      <= req_addr;
                            ddt_oe   <= req_write;
                            wdata_q  <= store_lane;
                            sign_q   <= req_signed;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    if (!ACKD_n) begin
                        state      <= ST_RESP;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        ddt_oe     <= 1'b0;
                        resp_valid <= 1'b1;
                        if (!WRITE) resp_rdata <= load_data;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= ST_RESP;
                        MREQ        <= 1'b0;
                        WRITE       <= 1'b0;
                        ddt_oe      <= 1'b0;
                        resp_valid  <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_master.sv
// tb/tb_dmem_bus_master.sv - vector table, corner sequences and randomized model check for dmem_bus_master
module tb_dmem_bus_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall, resp_valid, err_misaligned, err_timeout;
    logic [31:0] resp_rdata, DAD;
    logic        MREQ, WRITE, ACKD_n;
    logic [1:0]  SIZE;
    wire  [31:0] DDT;
    logic        mem_en;
    logic [31:0] mem_val;

    assign DDT = mem_en ? mem_val : 32'bz;

    always #5 clk = ~clk;

    dmem_bus_master #(.BIT_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .err_misaligned(err_misaligned), .err_timeout(err_timeout),
        .DAD(DAD), .DDT(DDT), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_to;
        logic [31:0] exp_lane;
        int          exp_resp_c;
        int          exp_mreq_c;
    } vec_t;

    typedef struct {
        int          resp_c;
        int          mreq_c;
        logic [31:0] rdata;
        logic        mis;
        logic        to;
        logic [31:0] dad;
        logic [1:0]  size;
        logic        write;
        logic [31:0] lane;
        logic        unstable;
        logic        stall_idle;
        logic [31:0] probe;
    } res_t;

    // Memory side: acks in the lat-th MREQ cycle; lat outside 1..TMO never acks.
    task automatic run_access(input vec_t v, output res_t r);
        int  c = 0;
        int  bc = 0;
        bit  done = 0;
        r = '{resp_c: -1, mreq_c: 0, rdata: 0, mis: 0, to: 0, dad: 0, size: 0,
              write: 0, lane: 0, unstable: 0, stall_idle: 0, probe: 0};
        @(negedge clk);
        req_valid = 1'b1; req_write = v.w; req_size = v.sz; req_signed = v.sg;
        req_addr = v.addr; req_wdata = v.wdata; ACKD_n = 1'b1; mem_en = 1'b0;
        #1 r.stall_idle = stall;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            req_valid = 1'b0; ACKD_n = 1'b1; mem_en = 1'b0;
            #1;
            if (resp_valid) begin
                r.resp_c = c; r.rdata = resp_rdata; r.mis = err_misaligned; r.to = err_timeout;
                done = 1;
            end else if (MREQ) begin
                bc++;
                if (!stall) r.unstable = 1'b1;
                if (bc == 1) begin
                    r.dad = DAD; r.size = SIZE; r.write = WRITE; r.lane = DDT;
                end else if (DAD !== r.dad || SIZE !== r.size || WRITE !== r.write) begin
                    r.unstable = 1'b1;
                end
                if (bc == v.lat) begin
                    ACKD_n = 1'b0;
                    if (!v.w) begin mem_val = v.mdata; mem_en = 1'b1; end
                end
            end
        end
        r.mreq_c = bc;
        mem_val = 32'h5A5A_5A00; mem_en = 1'b1;
        #1 r.probe = DDT;
        mem_en = 1'b0; ACKD_n = 1'b1;
    endtask

    task automatic check_access(input string tag, input vec_t v, input res_t r);
        check({tag, " resp_cycle"}, r.resp_c, v.exp_resp_c);
        check({tag, " mreq_cycles"}, r.mreq_c, v.exp_mreq_c);
        check({tag, " rdata"}, r.rdata, v.exp_rdata);
        check({tag, " err_misaligned"}, r.mis, v.exp_mis);
        check({tag, " err_timeout"}, r.to, v.exp_to);
        check({tag, " stall_on_request"}, r.stall_idle, 1'b1);
        check({tag, " ddt_released"}, r.probe, 32'h5A5A_5A00);
        if (!v.exp_mis) begin
            check({tag, " dad"}, r.dad, v.addr);
            check({tag, " size"}, r.size, v.sz);
            check({tag, " write"}, r.write, v.w);
            check({tag, " bus_stable"}, r.unstable, 1'b0);
            if (v.w) check({tag, " store_lane"}, r.lane, v.exp_lane);
        end
    endtask

    // Reference: outcome computed from the access rules with plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   e = v;
        longint m, x;
        bit     illegal;
        illegal = (v.sz == 2'd3) || (v.sz == 2'd0 && v.addr % 4 != 0) || (v.sz == 2'd1 && v.addr % 2 != 0);
        e.exp_rdata = 0; e.exp_mis = 0; e.exp_to = 0;
        m = (v.sz == 2'd1) ? 65536 : (v.sz == 2'd2) ? 256 : 64'h1_0000_0000;
        e.exp_lane = 32'(longint'(v.wdata) % m);
        if (illegal) begin
            e.exp_mis = 1; e.exp_resp_c = 1; e.exp_mreq_c = 0;
        end else if (v.lat < 1 || v.lat > TMO) begin
            e.exp_to = 1; e.exp_resp_c = TMO + 1; e.exp_mreq_c = TMO;
        end else begin
            e.exp_resp_c = v.lat + 1; e.exp_mreq_c = v.lat;
            if (!v.w) begin
                x = longint'(v.mdata) % m;
                if (v.sg && v.sz != 2'd0 && x >= m / 2) x = x - m;
                e.exp_rdata = 32'(x);
            end
        end
        return e;
    endfunction

    vec_t vecs[11];
    vec_t rv;
    res_t rr;

    initial begin
        // w sz sg addr wdata mdata lat | rdata mis to lane resp_c mreq_c
        vecs[0]  = '{0, 2'd0, 0, 32'h0800_0010, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 2, 1};
        vecs[1]  = '{0, 2'd2, 1, 32'h0800_0013, 32'h0, 32'h0000_0080, 1, 32'hFFFF_FF80, 0, 0, 32'h0, 2, 1};
        vecs[2]  = '{0, 2'd2, 0, 32'h0800_0013, 32'h0, 32'h0000_0080, 1, 32'h0000_0080, 0, 0, 32'h0, 2, 1};
        vecs[3]  = '{0, 2'd1, 1, 32'h0800_0002, 32'h0, 32'h0000_8001, 1, 32'hFFFF_8001, 0, 0, 32'h0, 2, 1};
        vecs[4]  = '{1, 2'd2, 0, 32'hF000_0000, 32'h1234_5641, 32'h0, 1, 32'h0, 0, 0, 32'h0000_0041, 2, 1};
        vecs[5]  = '{0, 2'd0, 0, 32'h0800_0002, 32'h0, 32'h1111_1111, 1, 32'h0, 1, 0, 32'h0, 1, 0};
        vecs[6]  = '{0, 2'd0, 0, 32'h0800_0020, 32'h0, 32'hCAFE_F00D, 0, 32'h0, 0, 1, 32'h0, 9, 8};
        vecs[7]  = '{0, 2'd0, 0, 32'h0800_0020, 32'h0, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 0, 0, 32'h0, 4, 3};
        vecs[8]  = '{0, 2'd3, 0, 32'h0800_0000, 32'h0, 32'h0, 1, 32'h0, 1, 0, 32'h0, 1, 0};
        vecs[9]  = '{1, 2'd1, 0, 32'h0800_0005, 32'hABCD_9876, 32'h0, 1, 32'h0, 1, 0, 32'h0, 1, 0};
        vecs[10] = '{1, 2'd1, 0, 32'hFF00_0006, 32'hABCD_9876, 32'h0, 2, 32'h0, 0, 0, 32'h0000_9876, 3, 2};

        rst = 1'b0; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; ACKD_n = 1'b1; mem_en = 1'b0; mem_val = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_val = 32'h5A5A_5A00; mem_en = 1'b1;
        #1;
        check("reset mreq", MREQ, 0);
        check("reset write", WRITE, 0);
        check("reset size", SIZE, 0);
        check("reset dad", DAD, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset rdata", resp_rdata, 0);
        check("reset errs", {err_misaligned, err_timeout}, 0);
        check("reset req_ready", req_ready, 1);
        check("reset ddt_released", DDT, 32'h5A5A_5A00);
        mem_en = 1'b0;
        rst = 1'b1;

        // Acknowledge while idle must be ignored.
        ACKD_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("idle_ack resp_valid", resp_valid, 0);
            check("idle_ack mreq", MREQ, 0);
        end
        ACKD_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i], rr);
            check_access($sformatf("vec%0d", i), vecs[i], rr);
        end

        // Request held through RESP is only accepted in the following IDLE cycle.
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd0; req_signed = 0; req_addr = 32'h0800_0001;
        @(negedge clk); #1;
        check("resp_hold resp_valid", resp_valid, 1);
        check("resp_hold req_ready", req_ready, 0);
        check("resp_hold stall", stall, 0);
        req_addr = 32'h0000_0100;
        @(negedge clk); #1;
        check("resp_hold mreq_idle", MREQ, 0);
        check("resp_hold ready_idle", req_ready, 1);
        check("resp_hold stall_idle", stall, 1);
        @(negedge clk);
        req_valid = 0; #1;
        check("resp_hold mreq_bus", MREQ, 1);
        check("resp_hold dad", DAD, 32'h0000_0100);
        ACKD_n = 0; mem_val = 32'h1122_3344; mem_en = 1;
        @(negedge clk);
        ACKD_n = 1; mem_en = 0; #1;
        check("resp_hold rdata", resp_rdata, 32'h1122_3344);
        check("resp_hold resp_valid2", resp_valid, 1);

        // Reset in the second BUS cycle aborts without a response.
        @(negedge clk);
        req_valid = 1; req_addr = 32'h0000_0040; req_size = 2'd0; req_write = 0;
        @(negedge clk);
        req_valid = 0; #1;
        check("abort mreq_first", MREQ, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("abort mreq", MREQ, 0);
        check("abort resp_valid", resp_valid, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort req_ready", req_ready, 1);
        check("abort resp_valid_after", resp_valid, 0);

        for (int i = 0; i < 40; i++) begin
            rv = vecs[0];
            rv.w     = 1'($urandom_range(0, 1));
            rv.sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rv.sg    = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.mdata = $urandom;
            rv.lat   = $urandom_range(1, TMO + 2);
            rv = model(rv);
            run_access(rv, rr);
            check_access($sformatf("rand%0d", i), rv, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
